// File: rtl/spi_slave_core.sv
`timescale 1ns/1ps
// SPI slave endpoint: oversampled sclk/mosi/ss_n, 1..MAX_LEN bit characters,
// buffered miso transmit word and valid/ack receive word.
module spi_slave_core #(
  parameter int MAX_LEN     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wb_clk_in,
  input  logic               wb_rst_in,
  input  logic               sclk_in,
  input  logic               ss_n_in,
  input  logic               mosi_in,
  output logic               miso_out,
  output logic               miso_oe,
  input  logic [4:0]         char_len,
  input  logic               lsb,
  input  logic               tx_neg,
  input  logic               rx_neg,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               tx_load,
  output logic               tx_empty,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ack,
  output logic               rx_overrun,
  output logic               tx_underrun,
  output logic               frame_err
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_s, r_ss_s, r_mosi_s;
  logic r_sclk_d, r_ss_d;

  logic [CW-1:0]      r_len, r_bit_cnt, r_tx_idx;
  logic               r_lsb, r_txneg, r_rxneg;
  logic [MAX_LEN-1:0] r_tx_buf, r_tx_sh, r_rx_sh, r_rx_data;
  logic               r_tx_empty, r_rx_valid, r_miso;
  logic               r_fresh, r_skip;
  logic               r_ovr, r_udr, r_ferr;

  logic w_sclk, w_ss, w_mosi;
  logic w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic w_start, w_end, w_act, w_smp, w_drv, w_drv_ok;
  logic w_done, w_reload, w_adv, w_load_sh;
  logic [CW-1:0]      w_len_in;
  logic [MAX_LEN-1:0] w_sh_new, w_rx_nxt;

  // Bit k in transmission order of an n-bit word.
  function automatic logic f_bit(input logic [MAX_LEN-1:0] w,
                                 input logic [CW-1:0] k,
                                 input logic [CW-1:0] n,
                                 input logic l);
    logic [(2**CW)-1:0] we;
    logic [CW-1:0]      p;
    we = (2**CW)'(w);
    p  = l ? k : (n - k - CW'(1));
    return we[p];
  endfunction

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      r_sclk_s <= '0;
      r_ss_s   <= '1;
      r_mosi_s <= '0;
      r_sclk_d <= 1'b0;
      r_ss_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], sclk_in};
      r_ss_s   <= {r_ss_s[SYNC_STAGES-2:0], ss_n_in};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], mosi_in};
      r_sclk_d <= w_sclk;
      r_ss_d   <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_s[SYNC_STAGES-1];
  assign w_ss        = r_ss_s[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_s[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;

  assign w_len_in  = (char_len == '0) ? CW'(MAX_LEN) : CW'(char_len);
  assign w_start   = (r_state == S_IDLE) & w_ss_fall;
  assign w_end     = (r_state == S_ACTIVE) & w_ss_rise;
  assign w_act     = (r_state == S_ACTIVE) & ~w_ss_rise;
  assign w_smp     = w_act & (r_rxneg ? w_sclk_fall : w_sclk_rise);
  assign w_drv     = w_act & (r_txneg ? w_sclk_fall : w_sclk_rise);
  // first drive edge is skipped only if it comes before any sample edge
  assign w_drv_ok  = w_drv & ~(r_skip & ~w_smp);
  assign w_done    = w_smp & ((r_bit_cnt + CW'(1)) == r_len);
  assign w_reload  = w_drv_ok & (r_fresh | w_done);
  assign w_adv     = w_drv_ok & (r_tx_idx != (r_len - CW'(1)));
  assign w_load_sh = w_start | w_reload;
  assign w_sh_new  = r_tx_empty ? '0 : r_tx_buf;

  always_comb begin
    w_rx_nxt = r_rx_sh;
    if (r_lsb) w_rx_nxt[r_bit_cnt[IW-1:0]] = w_mosi;
    else       w_rx_nxt = {r_rx_sh[MAX_LEN-2:0], w_mosi};
  end

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_ss_fall) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_ss_rise) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    miso_oe = (r_state == S_ACTIVE);
  end

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_tx_idx   <= '0;
      r_lsb      <= 1'b0;
      r_txneg    <= 1'b0;
      r_rxneg    <= 1'b0;
      r_tx_buf   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_tx_empty <= 1'b1;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
      r_fresh    <= 1'b0;
      r_skip     <= 1'b0;
      r_ovr      <= 1'b0;
      r_udr      <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_ovr  <= w_done & r_rx_valid & ~rx_ack;
      r_udr  <= w_load_sh & r_tx_empty;
      r_ferr <= w_end & (r_bit_cnt != '0);
      if (tx_load) begin
        r_tx_buf   <= tx_data;
        r_tx_empty <= 1'b0;
      end else if (w_load_sh) begin
        r_tx_empty <= 1'b1;
      end
      if (w_load_sh) r_tx_sh <= w_sh_new;
      if (w_start) begin
        r_len     <= w_len_in;
        r_lsb     <= lsb;
        r_txneg   <= tx_neg;
        r_rxneg   <= rx_neg;
        r_bit_cnt <= '0;
        r_rx_sh   <= '0;
        r_tx_idx  <= '0;
        r_fresh   <= 1'b0;
        r_skip    <= 1'b1;
        r_miso    <= f_bit(w_sh_new, '0, w_len_in, lsb);
      end
      if (w_end) begin
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
      end
      if (w_smp | w_drv) r_skip <= 1'b0;
      if (w_smp) begin
        if (w_done) begin
          r_bit_cnt <= '0;
          r_rx_sh   <= '0;
          r_rx_data <= w_rx_nxt;
          r_fresh   <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
          r_rx_sh   <= w_rx_nxt;
        end
      end
      if (w_reload) begin
        r_tx_idx <= '0;
        r_fresh  <= 1'b0;
        r_miso   <= f_bit(w_sh_new, '0, r_len, r_lsb);
      end else if (w_adv) begin
        r_tx_idx <= r_tx_idx + CW'(1);
        r_miso   <= f_bit(r_tx_sh, r_tx_idx + CW'(1), r_len, r_lsb);
      end
      if (w_done)      r_rx_valid <= 1'b1;
      else if (rx_ack) r_rx_valid <= 1'b0;
    end
  end

  assign miso_out    = r_miso;
  assign tx_empty    = r_tx_empty;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign rx_overrun  = r_ovr;
  assign tx_underrun = r_udr;
  assign frame_err   = r_ferr;

endmodule

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
// Bench for spi_slave_core: bit-banged SPI master, scoreboard queues for
// expected rx words and expected miso words.
module tb_spi_slave_core;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic        miso_out, miso_oe;
  logic [4:0]  char_len = '0;
  logic        lsb = 1'b0, tx_neg = 1'b0, rx_neg = 1'b1;
  logic [31:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic        tx_empty;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        rx_overrun, tx_underrun, frame_err;

  int n_tests = 0, n_fail = 0;
  int n_ovr = 0, n_udr = 0, n_ferr = 0;
  logic [31:0] q_rx[$];
  logic [31:0] q_mi[$];

  always #5 clk = ~clk;

  spi_slave_core #(.MAX_LEN(32), .SYNC_STAGES(SYNC)) dut (
    .wb_clk_in(clk), .wb_rst_in(rst_n),
    .sclk_in(sclk), .ss_n_in(ss_n), .mosi_in(mosi),
    .miso_out(miso_out), .miso_oe(miso_oe),
    .char_len(char_len), .lsb(lsb), .tx_neg(tx_neg), .rx_neg(rx_neg),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (rx_overrun)  n_ovr++;
    if (tx_underrun) n_udr++;
    if (frame_err)   n_ferr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic cfg(input logic [4:0] cl, input logic l);
    char_len = cl;
    lsb      = l;
    tx_neg   = 1'b0;
    rx_neg   = 1'b1;
  endtask

  task automatic load(input logic [31:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic sel();
    ss_n = 1'b0;
    half();
    half();
  endtask

  task automatic desel();
    half();
    ss_n = 1'b1;
    half();
    half();
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 200 && !rx_valid; t++) @(negedge clk);
  endtask

  // master drives mosi on rising sclk, samples miso on falling sclk
  task automatic xchar(input int nb, input int len, input bit l,
                       input logic [31:0] mo, output logic [31:0] mi);
    int p;
    mi = '0;
    for (int k = 0; k < nb; k++) begin
      p    = l ? k : len - 1 - k;
      sclk = 1'b1;
      mosi = mo[p];
      half();
      mi[p] = miso_out;
      sclk  = 1'b0;
      half();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg(5'd4, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({miso_out, miso_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_miso: got %b want 00", {miso_out, miso_oe});
    end
    n_tests++;
    if (tx_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx_empty: got %b want 1", tx_empty);
    end
    n_tests++;
    if (rx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h want 0", rx_data);
    end
    n_tests++;
    if ({rx_valid, rx_overrun, tx_underrun, frame_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {rx_valid, rx_overrun, tx_underrun, frame_err});
    end
    rst_n = 1'b1;
    half();
  endtask

  task automatic test_msb4();
    logic [31:0] mi, e;
    int b_o, b_u, b_f;
    b_o = n_ovr; b_u = n_udr; b_f = n_ferr;
    cfg(5'd4, 1'b0);
    load(32'h0000_000A);
    q_mi.push_back(32'h0000_000A);
    q_rx.push_back(32'h0000_000F);
    sel();
    n_tests++;
    if ({miso_oe, miso_out} !== 2'b11) begin
      n_fail++;
      $display("FAIL msb4_first_bit: oe,miso got %b want 11",
               {miso_oe, miso_out});
    end
    xchar(4, 4, 1'b0, 32'h0000_000F, mi);
    desel();
    e = q_mi.pop_front();
    n_tests++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL msb4_miso: got %h want %h", mi, e);
    end
    wait_valid();
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL msb4_rx: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    n_tests++;
    if (n_ovr != b_o || n_udr != b_u || n_ferr != b_f) begin
      n_fail++;
      $display("FAIL msb4_pulses: ovr %0d udr %0d ferr %0d want 0 0 0",
               n_ovr - b_o, n_udr - b_u, n_ferr - b_f);
    end
    ack();
  endtask

  task automatic test_lsb4();
    logic [31:0] mi, e;
    cfg(5'd4, 1'b1);
    load(32'h0000_236F);
    q_mi.push_back(32'h0000_000F);
    q_rx.push_back(32'h0000_000A);
    sel();
    xchar(4, 4, 1'b1, 32'h0000_000A, mi);
    desel();
    e = q_mi.pop_front();
    n_tests++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL lsb4_miso: got %h want %h", mi, e);
    end
    wait_valid();
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL lsb4_rx: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    ack();
    n_tests++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb4_ack: rx_valid got %b want 0", rx_valid);
    end
  endtask

  task automatic test_len32();
    logic [31:0] mi, e;
    cfg(5'd0, 1'b0);
    load(32'hDEAD_BEEF);
    q_mi.push_back(32'hDEAD_BEEF);
    q_rx.push_back(32'h1234_5678);
    sel();
    xchar(32, 32, 1'b0, 32'h1234_5678, mi);
    desel();
    e = q_mi.pop_front();
    n_tests++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL len32_miso: got %h want %h", mi, e);
    end
    wait_valid();
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL len32_rx: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [31:0] mi0, mi1, e;
    int b_o, b_u, b_f;
    cfg(5'd8, 1'b0);
    load(32'h0000_00A5);
    b_o = n_ovr; b_u = n_udr; b_f = n_ferr;
    q_mi.push_back(32'h0000_00A5);
    q_mi.push_back(32'h0000_0000);
    q_rx.push_back(32'h0000_003C);
    q_rx.push_back(32'h0000_00C3);
    sel();
    xchar(8, 8, 1'b0, 32'h0000_003C, mi0);
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL b2b_rx0: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    xchar(8, 8, 1'b0, 32'h0000_00C3, mi1);
    desel();
    e = q_mi.pop_front();
    n_tests++;
    if (mi0 !== e) begin
      n_fail++;
      $display("FAIL b2b_miso0: got %h want %h", mi0, e);
    end
    e = q_mi.pop_front();
    n_tests++;
    if (mi1 !== e) begin
      n_fail++;
      $display("FAIL b2b_miso1: got %h want %h", mi1, e);
    end
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL b2b_rx1: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    n_tests++;
    if (n_udr - b_u != 1 || n_ovr - b_o != 1 || n_ferr != b_f) begin
      n_fail++;
      $display("FAIL b2b_pulses: udr %0d ovr %0d ferr %0d want 1 1 0",
               n_udr - b_u, n_ovr - b_o, n_ferr - b_f);
    end
    ack();
  endtask

  task automatic test_frame_err();
    logic [31:0] mi;
    int b_f, lat;
    cfg(5'd8, 1'b0);
    load(32'h0000_0055);
    b_f = n_ferr;
    sel();
    xchar(3, 8, 1'b0, 32'h0000_00FF, mi);
    @(negedge clk);
    ss_n = 1'b1;
    for (lat = 1; lat <= SYNC + 1; lat++) begin
      @(posedge clk);
      #1;
      if (!miso_oe) break;
    end
    n_tests++;
    if (miso_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_oe_latency: miso_oe got %b want 0 within %0d cycles",
               miso_oe, SYNC + 1);
    end
    half();
    n_tests++;
    if (n_ferr - b_f != 1) begin
      n_fail++;
      $display("FAIL ferr_pulse: got %0d pulses want 1", n_ferr - b_f);
    end
    n_tests++;
    if (rx_valid !== 1'b0 || miso_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_state: valid %b miso %b want 0 0", rx_valid, miso_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] mi, e;
    int b_o, b_u, b_f;
    cfg(5'd8, 1'b0);
    load(32'h0000_0011);
    sel();
    load(32'h0000_003C);
    xchar(4, 8, 1'b0, 32'h0000_00FF, mi);
    b_o = n_ovr; b_u = n_udr; b_f = n_ferr;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({miso_oe, miso_out, tx_empty, rx_valid} !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_flags: oe,miso,empty,valid got %b want 0010",
               {miso_oe, miso_out, tx_empty, rx_valid});
    end
    n_tests++;
    if (rx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_rx_data: got %h want 0", rx_data);
    end
    ss_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    half();
    n_tests++;
    if (n_ovr != b_o || n_udr != b_u || n_ferr != b_f) begin
      n_fail++;
      $display("FAIL rstmid_pulses: ovr %0d udr %0d ferr %0d want 0 0 0",
               n_ovr - b_o, n_udr - b_u, n_ferr - b_f);
    end
    load(32'h0000_0096);
    q_mi.push_back(32'h0000_0096);
    q_rx.push_back(32'h0000_005A);
    sel();
    xchar(8, 8, 1'b0, 32'h0000_005A, mi);
    desel();
    e = q_mi.pop_front();
    n_tests++;
    if (mi !== e) begin
      n_fail++;
      $display("FAIL rstmid_miso: got %h want %h", mi, e);
    end
    wait_valid();
    e = q_rx.pop_front();
    n_tests++;
    if (rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL rstmid_rx: valid %b data %h want 1 %h", rx_valid, rx_data, e);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_msb4();
    test_lsb4();
    test_len32();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Synthesizable SPI slave endpoint, the far end of the link driven by spi_topmodule. It oversamples sclk/mosi/ss_n in the system clock domain and receives one character of 1–32 bits per frame segment. It shifts a pre-loaded transmit word out on miso and presents each received word on a simple valid/ack parallel interface. It replaces the behavioural spi_slave in silicon-bound builds.

Parameters:
MAX_LEN, 32, width of tx/rx data words; char_len 0 encodes MAX_LEN
SYNC_STAGES, 2, synchroniser depth on sclk_in, mosi_in, ss_n_in (min 2)

Ports:
wb_clk_in  in  1  system clock, all logic on rising edge
wb_rst_in  in  1  asynchronous, active-low reset
sclk_in  in  1  SPI clock from master, asynchronous
ss_n_in  in  1  slave select, active low, asynchronous
mosi_in  in  1  serial data from master
miso_out  out  1  serial data to master
miso_oe  out  1  miso output enable, high only while frame active
char_len  in  5  bits per character, 0 = 32
lsb  in  1  1 = LSB first, 0 = MSB first (both directions)
tx_neg  in  1  1 = miso updates on sclk falling edge, 0 = rising
rx_neg  in  1  1 = mosi sampled on sclk falling edge, 0 = rising
tx_data  in  32  word to transmit
tx_load  in  1  one-cycle strobe: capture tx_data into tx buffer
tx_empty  out  1  tx buffer free
rx_data  out  32  last received word, bits >= char_len zero
rx_valid  out  1  rx_data holds unacknowledged word
rx_ack  in  1  clears rx_valid
rx_overrun  out  1  one-cycle pulse: word completed while rx_valid high
tx_underrun  out  1  one-cycle pulse: character started with tx_empty high
frame_err  out  1  one-cycle pulse: ss_n rose mid-character

Behaviour:
- Reset (wb_rst_in low, async): state IDLE; miso_out 0, miso_oe 0, tx_empty 1, rx_data 0, rx_valid 0, all pulses 0, bit counter 0, synchronisers forced to idle (sclk 0, ss_n 1).
- Inputs pass SYNC_STAGES flops plus one edge-detect flop. sclk rise/fall and ss_n fall/rise events are single-cycle strobes. Input-pin-to-event latency is SYNC_STAGES+1 cycles. sclk half-period must be >= SYNC_STAGES+2 wb_clk cycles; a divider of 4 (half-period 5) qualifies.
- tx buffer: tx_load captures tx_data and clears tx_empty. A load while tx_empty=0 overwrites. The buffer transfers to the shift register at character start and sets tx_empty.
- States IDLE, ACTIVE.
- IDLE -> ACTIVE on ss_n fall:
  - latch char_len/lsb/tx_neg/rx_neg; changes during the frame are ignored;
  - load shifter (zeros plus tx_underrun pulse if tx_empty);
  - bit_cnt=0, miso_oe=1;
  - miso_out = first bit (bit 0 if lsb, else bit N-1) in the same cycle as the event.
- ACTIVE, sample edge (per rx_neg):
  - shift mosi into rx shifter (LSB-first fills bit 0 upward in order of arrival; MSB-first fills down to bit 0), then bit_cnt++;
  - when bit_cnt reaches N: rx_data <= assembled word, rx_valid=1 (rx_overrun pulse if already 1; data is overwritten), bit_cnt=0;
  - reload shifter from tx buffer for the next character (continuous frames).
- ACTIVE, drive edge (per tx_neg): advance miso_out to the next bit. The drive edge preceding the first sample edge is ignored when the first bit was already presented at ss_n fall. Bits beyond N are not driven: miso holds the last bit.
- ACTIVE -> IDLE on ss_n rise: miso_oe=0, miso_out=0. frame_err pulses if bit_cnt != 0, and the partial word is discarded.
- rx_ack clears rx_valid. If rx_ack and a completion coincide, completion wins: rx_valid stays 1, no overrun.
- tx_load and character-start transfer in the same cycle: the old buffer transfers, the new data is held, tx_empty=0.
- A sclk edge coincident with ss_n rise is ignored.
- Reset mid-frame aborts immediately with no pulses.

Test Plan:
- char_len=4, lsb=0, tx_neg=0, rx_neg=1, tx_data=32'h0000_000A; master sends 4'hF -> miso bits 1,0,1,0; rx_data=32'h0000_000F, rx_valid=1, no error pulses.
- char_len=4, lsb=1, tx_data=32'h0000_236F; master sends 4'b0101 LSB first -> miso 1,1,1,1; rx_data=32'h0000_000A.
- char_len=0 (32 bits), tx_data=32'hDEAD_BEEF, master sends 32'h1234_5678 MSB first -> rx_data=32'h1234_5678; master receives 32'hDEAD_BEEF.
- Two back-to-back 8-bit characters under one ss_n low with only the first loaded -> second transmits 8'h00, tx_underrun pulses once, second rx completion with rx_valid unacked -> rx_overrun pulses once.
- ss_n raised after 3 of 8 bits -> frame_err pulse, rx_valid unchanged, miso_oe=0 within SYNC_STAGES+1 cycles.
- wb_rst_in low mid-character -> all outputs at reset values immediately; next full frame received correctly.
